ex_stage: RTL

//  Execute stage feeding the MEM stage: ALU ops, load/store address generation, iterative MUL.

---
 rtl/ex_stage_pkg.sv | 42 ++++
 rtl/ex_mul_iter.sv | 60 ++++++
 rtl/ex_stage.sv | 62 ++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: bus structs, opcodes, ALU funct encodings and the shared ALU function.
package ex_stage_pkg;

    typedef enum logic [3:0] {OP_NOP, OP_ALUR, OP_ALUI, OP_LW, OP_SW, OP_MUL, OP_BR, OP_JAL} opcode_t;
    typedef enum logic [2:0] {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SLT} funct_t;
    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;

    localparam int FUNCT_LSB = 12;

    typedef struct packed {
        logic [31:0] instruction;
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic [31:0] imm;
    } id_ex_bus_t;

    typedef struct packed {
        logic [31:0] instruction;
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] b_val;
    } ex_mem_bus_t;

    localparam ex_mem_bus_t EX_MEM_BUBBLE = '{instruction: '0, opcode: OP_NOP, rd: '0, alu_result: '0, b_val: '0};

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input funct_t f);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_XOR:   return a ^ b;
            F_SLL:   return a << b[4:0];
            F_SRL:   return a >> b[4:0];
            default: return {31'b0, $signed(a) < $signed(b)};
        endcase
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative multiplier, MUL_BITS_PER_CYCLE multiplier bits per cycle; the
// start cycle already consumes the first chunk, so IDLE->DONE spans 32/MUL_BITS_PER_CYCLE cycles.
module ex_mul_iter
    import ex_stage_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    localparam int K = MUL_BITS_PER_CYCLE;
    localparam int STEPS = 32 / K;
    localparam logic [5:0] LAST = 6'(STEPS - 1);

    mul_state_t state, state_next;
    logic [31:0] mcand, mplier, acc;
    logic [5:0] count;

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= M_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            M_IDLE:  state_next = start ? (STEPS == 1 ? M_DONE : M_BUSY) : M_IDLE;
            M_BUSY:  state_next = count == LAST ? M_DONE : M_BUSY;
            default: state_next = hold ? M_DONE : M_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            count <= '0;
        end else if (state == M_IDLE && start) begin
            mcand <= a << K;
            mplier <= b >> K;
            acc <= a * 32'(b[K-1:0]);
            count <= 6'd1;
        end else if (state == M_BUSY) begin
            mcand <= mcand << K;
            mplier <= mplier >> K;
            acc <= acc + mcand * 32'(mplier[K-1:0]);
            count <= count + 6'd1;
        end

    assign busy = state == M_BUSY;
    assign done = state == M_DONE;
    assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ALU, address generation, optional iterative MUL (EX_MUL_EN) and the EX->MEM register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  id_ex_bus_t  id_ex_bus_in,
    input  logic        mem_stall,
    output ex_mem_bus_t ex_mem_bus_out,
    output logic        stall
);
    logic        is_mul, mul_start, mul_busy, mul_done, mul_stall;
    logic [31:0] mul_product;
    ex_mem_bus_t ex_next;
    funct_t      funct;

    assign is_mul = id_ex_bus_in.opcode == OP_MUL;
    assign mul_start = is_mul && !mem_stall && !mul_busy && !mul_done;
    assign funct = funct_t'(id_ex_bus_in.instruction[FUNCT_LSB +: 3]);

`ifdef EX_MUL_EN
    ex_mul_iter #(.MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)) u_mul (
        .clock(clock),
        .reset(reset),
        .start(mul_start),
        .a(id_ex_bus_in.a_val),
        .b(id_ex_bus_in.b_val),
        .hold(mem_stall),
        .busy(mul_busy),
        .done(mul_done),
        .product(mul_product)
    );
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b1;
    assign mul_product = 32'h0;
`endif

    // The start cycle stalls too so the MUL stays on the input until DONE.
    assign mul_stall = mul_start | mul_busy;
    assign stall = mem_stall | mul_stall;

    always_comb begin
        ex_next.instruction = id_ex_bus_in.instruction;
        ex_next.opcode = id_ex_bus_in.opcode;
        ex_next.rd = id_ex_bus_in.rd;
        ex_next.b_val = id_ex_bus_in.b_val;
        case (id_ex_bus_in.opcode)
            OP_ALUR: ex_next.alu_result = alu(id_ex_bus_in.a_val, id_ex_bus_in.b_val, funct);
            OP_ALUI: ex_next.alu_result = alu(id_ex_bus_in.a_val, id_ex_bus_in.imm, funct);
            OP_MUL:  ex_next.alu_result = mul_product;
            default: ex_next.alu_result = id_ex_bus_in.a_val + id_ex_bus_in.imm;
        endcase
        if (is_mul && !mul_done) ex_next = EX_MEM_BUBBLE;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) ex_mem_bus_out <= EX_MEM_BUBBLE;
        else if (!mem_stall) ex_mem_bus_out <= ex_next;
endmodule
